lc3_fetch_unit: RTL and testbench

- LC3 fetch stage. Consumes the controller's fetch-control bundle (enable_updatePC, enable_fetch, taddr, br_taken).
- Keeps the PC and issues requests to instruction memory over a req/ack handshake.
- Buffers returned instructions in a small FIFO that feeds decode through valid/ready.
- Handles branch redirects, including redirects that occur while a memory request is in flight.

---
 rtl/lc3_fetch_pkg.sv | 27 ++
 rtl/lc3_fetch_fifo.sv | 75 +++++++
 rtl/lc3_fetch_unit.sv | 157 +++++++++++++++
 tb/tb_lc3_fetch_unit.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC3 fetch stage.
package lc3_fetch_pkg;

  localparam int LC3_ADDR_W = 16;
  localparam int FQ_COUNT_W = 3;
  localparam logic [LC3_ADDR_W-1:0] DEFAULT_RESET_PC = 16'h3000;

  // IDLE: no request outstanding. REQ: request outstanding, response wanted.
  // DISCARD: request outstanding, but a redirect made its response stale.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

  // One buffered instruction plus the sequential address that follows it.
  typedef struct packed {
    logic [LC3_ADDR_W-1:0] instr;
    logic [LC3_ADDR_W-1:0] npc;
  } fq_entry_t;

  // Sequential address increment; wraps modulo 2^16.
  function automatic logic [LC3_ADDR_W-1:0] addr_inc(input logic [LC3_ADDR_W-1:0] a);
    return a + LC3_ADDR_W'(1);
  endfunction

endpackage

// File: rtl/lc3_fetch_fifo.sv
// Small instruction queue between fetch and decode. The head is fall-through:
// it is visible on the same cycle it is written. The head reads as zero when
// the queue is empty.
module lc3_fetch_fifo
  import lc3_fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  i_push,
  input  fq_entry_t             i_push_data,
  input  logic                  i_pop,
  input  logic                  i_flush,
  output fq_entry_t             o_head,
  output logic [FQ_COUNT_W-1:0] o_count,
  output logic                  o_empty,
  output logic                  o_full
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  fq_entry_t             r_mem [QDEPTH];
  logic [PW-1:0]         r_rd_ptr;
  logic [PW-1:0]         r_wr_ptr;
  logic [FQ_COUNT_W-1:0] r_count;

  logic w_do_push;
  logic w_do_pop;

  // Pointer advance with wrap at QDEPTH, so non-power-of-two depths work.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // A flush wins over a push in the same cycle; a pop on empty is ignored.
  assign w_do_push = i_push & ~i_flush;
  assign w_do_pop  = i_pop & ~o_empty;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == FQ_COUNT_W'(QDEPTH));
  assign o_count = r_count;
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write.
  // NOTE: the data array has no reset; every read of it is gated by the
  // occupancy count, which is reset, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers and occupancy; flush empties the queue in one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + FQ_COUNT_W'(1);
        2'b01:   r_count <= r_count - FQ_COUNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/lc3_fetch_unit.sv
// LC3 fetch stage: owns the PC, runs the single-outstanding req/ack handshake
// with instruction memory, and feeds decode through a small instruction queue.
// Redirects that land while a request is in flight let the request finish on
// the bus but throw its response away. The reset input is expected to be
// released synchronously to clock by the surrounding reset logic.
module lc3_fetch_unit
  import lc3_fetch_pkg::*;
#(
  parameter logic [LC3_ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int                    QDEPTH   = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable_updatePC,
  input  logic                  enable_fetch,
  input  logic [LC3_ADDR_W-1:0] taddr,
  input  logic                  br_taken,
  output logic                  imem_req,
  output logic [LC3_ADDR_W-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [LC3_ADDR_W-1:0] imem_rdata,
  output logic                  instrmem_rd,
  output logic [LC3_ADDR_W-1:0] pc,
  output logic [LC3_ADDR_W-1:0] npc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [LC3_ADDR_W-1:0] instr_out,
  output logic [LC3_ADDR_W-1:0] instr_npc,
  output logic [FQ_COUNT_W-1:0] fq_count
);

  fetch_state_e          r_state;
  logic [LC3_ADDR_W-1:0] r_pc;
  logic [LC3_ADDR_W-1:0] r_addr;

  fetch_state_e          w_state_nxt;
  logic [LC3_ADDR_W-1:0] w_pc_nxt;
  logic [LC3_ADDR_W-1:0] w_addr_nxt;
  logic                  w_push;
  logic                  w_flush;
  logic                  w_pop;
  logic                  w_redirect;
  fq_entry_t             w_push_data;
  fq_entry_t             w_head;
  logic                  w_empty;
  logic                  w_full;

  assign w_redirect  = enable_updatePC & br_taken;
  assign w_pop       = instr_valid & instr_ready;
  assign w_push_data = '{instr: imem_rdata, npc: addr_inc(r_addr)};

  // The request is outstanding in every state but IDLE, so reset drops it
  // as soon as the state register clears.
  assign imem_req    = (r_state != IDLE);
  assign instrmem_rd = imem_req;
  assign imem_addr   = r_addr;
  assign pc          = r_pc;
  assign npc         = addr_inc(r_pc);
  assign instr_valid = ~w_empty;
  assign instr_out   = w_head.instr;
  assign instr_npc   = w_head.npc;

  // State, PC and request-address registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed by the combinational block.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_addr  <= w_addr_nxt;
    end
  end

  // Next-state, PC update, queue push/flush decisions.
  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_addr_nxt  = r_addr;
    w_push      = 1'b0;
    w_flush     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_redirect) begin
          w_pc_nxt = taddr;
          w_flush  = 1'b1;
        end else if (enable_fetch && !w_full) begin
          // Issuing only with a free slot means the push can never overflow.
          w_addr_nxt  = r_pc;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        if (imem_ack) begin
          w_state_nxt = IDLE;
          if (w_redirect) begin
            w_pc_nxt = taddr;
            w_flush  = 1'b1;
          end else begin
            w_push   = 1'b1;
            w_pc_nxt = addr_inc(r_pc);
          end
        end else if (w_redirect) begin
          w_pc_nxt    = taddr;
          w_flush     = 1'b1;
          w_state_nxt = DISCARD;
        end
      end
      DISCARD: begin
        // The stale response is dropped; later redirects keep moving the PC.
        if (w_redirect) begin
          w_pc_nxt = taddr;
          w_flush  = 1'b1;
        end
        if (imem_ack) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  lc3_fetch_fifo #(
    .QDEPTH(QDEPTH)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .i_push     (w_push),
    .i_push_data(w_push_data),
    .i_pop      (w_pop),
    .i_flush    (w_flush),
    .o_head     (w_head),
    .o_count    (fq_count),
    .o_empty    (w_empty),
    .o_full     (w_full)
  );

  // The address must not move while the memory is still working on it.
  a_addr_stable: assert property (
    @(posedge clock) disable iff (!reset)
      (imem_req && !imem_ack) |=> (imem_req && $stable(imem_addr))
  );

  // A push without a pop must always find a free slot.
  a_no_overflow: assert property (
    @(posedge clock) disable iff (!reset)
      (w_push && !w_pop) |-> !w_full
  );

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Bench for lc3_fetch_unit: directed scenarios plus a randomized run, all
// checked every cycle against a transaction-level model (a PC, an
// outstanding-request flag, a drop flag and a queue of decoded entries).
module tb_lc3_fetch_unit;
  import lc3_fetch_pkg::*;

  localparam int          QDEPTH   = 2;
  localparam logic [15:0] RESET_PC = 16'h3000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_updatePC = 1'b0;
  logic        enable_fetch = 1'b0;
  logic [15:0] taddr = '0;
  logic        br_taken = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        instrmem_rd;
  logic [15:0] pc;
  logic [15:0] npc;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [15:0] instr_out;
  logic [15:0] instr_npc;
  logic [2:0]  fq_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  logic [15:0] m_pc;
  logic [15:0] m_addr;
  bit          m_busy;
  bit          m_drop;
  fq_entry_t   m_q[$];

  // Observation logs for the directed sequence checks.
  logic [15:0] q_req_addr[$];
  logic [15:0] q_pop_npc[$];

  always #5 clock = ~clock;

  lc3_fetch_unit #(
    .RESET_PC(RESET_PC),
    .QDEPTH  (QDEPTH)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable_updatePC(enable_updatePC),
    .enable_fetch   (enable_fetch),
    .taddr          (taddr),
    .br_taken       (br_taken),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instrmem_rd    (instrmem_rd),
    .pc             (pc),
    .npc            (npc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_out      (instr_out),
    .instr_npc      (instr_npc),
    .fq_count       (fq_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    m_pc   = RESET_PC;
    m_addr = '0;
    m_busy = 1'b0;
    m_drop = 1'b0;
    m_q.delete();
  endtask

  // Advance the model across one rising edge using the inputs held during it.
  task automatic model_step();
    bit        redir;
    bit        pop;
    bit        flush;
    bit        push;
    fq_entry_t e;
    redir = enable_updatePC && br_taken;
    pop   = (m_q.size() > 0) && instr_ready;
    flush = 1'b0;
    push  = 1'b0;
    e     = '0;
    if (!m_busy) begin
      if (redir) begin
        m_pc  = taddr;
        flush = 1'b1;
      end else if (enable_fetch && m_q.size() < QDEPTH) begin
        m_busy = 1'b1;
        m_drop = 1'b0;
        m_addr = m_pc;
      end
    end else if (imem_ack) begin
      m_busy = 1'b0;
      if (redir) begin
        m_pc  = taddr;
        flush = 1'b1;
      end else if (!m_drop) begin
        e.instr = imem_rdata;
        e.npc   = m_addr + 16'd1;
        push    = 1'b1;
        m_pc    = m_pc + 16'd1;
      end
    end else if (redir) begin
      m_pc   = taddr;
      flush  = 1'b1;
      m_drop = 1'b1;
    end
    if (pop)   void'(m_q.pop_front());
    if (flush) m_q.delete();
    if (push)  m_q.push_back(e);
  endtask

  task automatic check_outputs();
    logic [15:0] exp_npc;
    exp_npc = m_pc + 16'd1;
    check("imem_req", imem_req, m_busy);
    check("instrmem_rd", instrmem_rd, m_busy);
    check("imem_addr", imem_addr, m_addr);
    check("pc", pc, m_pc);
    check("npc", npc, exp_npc);
    check("instr_valid", instr_valid, m_q.size() > 0);
    check("fq_count", fq_count, m_q.size());
    if (m_q.size() > 0) begin
      check("instr_out", instr_out, m_q[0].instr);
      check("instr_npc", instr_npc, m_q[0].npc);
    end
  endtask

  // One clock: compare on the falling edge, then step the model on the rising.
  task automatic do_cycle();
    @(negedge clock);
    check_outputs();
    if (imem_req && imem_ack) q_req_addr.push_back(imem_addr);
    if (instr_valid && instr_ready) q_pop_npc.push_back(instr_npc);
    @(posedge clock);
    model_step();
    #1;
  endtask

  // Drive one cycle of stimulus; the memory only acks an outstanding request.
  task automatic step(input bit fe, input bit rd, input bit br, input bit upc,
                      input logic [15:0] ta, input int ack_pct);
    enable_fetch    = fe;
    instr_ready     = rd;
    br_taken        = br;
    enable_updatePC = upc;
    taddr           = ta;
    imem_ack        = m_busy && (int'($urandom_range(0, 99)) < ack_pct);
    imem_rdata      = 16'($urandom);
    do_cycle();
  endtask

  task automatic apply_reset();
    reset           = 1'b0;
    enable_fetch    = 1'b0;
    instr_ready     = 1'b0;
    br_taken        = 1'b0;
    enable_updatePC = 1'b0;
    imem_ack        = 1'b0;
    taddr           = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_outputs();
    check("rst_instr_out", instr_out, 16'h0000);
    check("rst_instr_npc", instr_npc, 16'h0000);
    #2 reset = 1'b1;
    q_req_addr.delete();
    q_pop_npc.delete();
  endtask

  initial begin
    // Sequential fetch with same-cycle ack.
    apply_reset();
    repeat (6) step(1, 1, 0, 0, 16'h0, 100);
    check("seq_pc_after_3", pc, 16'h3003);
    repeat (3) step(0, 1, 0, 0, 16'h0, 100);
    check("seq_req_n", q_req_addr.size() >= 3, 1);
    check("seq_pop_n", q_pop_npc.size() >= 3, 1);
    if (q_req_addr.size() >= 3 && q_pop_npc.size() >= 3) begin
      check("seq_addr0", q_req_addr[0], 16'h3000);
      check("seq_addr1", q_req_addr[1], 16'h3001);
      check("seq_addr2", q_req_addr[2], 16'h3002);
      check("seq_npc0", q_pop_npc[0], 16'h3001);
      check("seq_npc1", q_pop_npc[1], 16'h3002);
      check("seq_npc2", q_pop_npc[2], 16'h3003);
    end

    // Back-pressure: queue fills, issuing stops, one pop reopens it.
    apply_reset();
    repeat (10) step(1, 0, 0, 0, 16'h0, 100);
    check("bp_count", fq_count, 3'd2);
    check("bp_no_req", imem_req, 1'b0);
    check("bp_acks", q_req_addr.size(), 2);
    step(1, 1, 0, 0, 16'h0, 0);
    step(1, 0, 0, 0, 16'h0, 0);
    check("bp_reissue_req", imem_req, 1'b1);
    check("bp_reissue_addr", imem_addr, 16'h3002);
    repeat (6) step(0, 1, 0, 0, 16'h0, 100);

    // Redirect while the request waits; stale response is dropped.
    apply_reset();
    step(1, 1, 0, 0, 16'h0, 0);
    step(1, 1, 1, 1, 16'h4000, 0);
    step(1, 1, 0, 0, 16'h0, 0);
    step(1, 1, 0, 0, 16'h0, 0);
    check("disc_req_held", imem_req, 1'b1);
    check("disc_addr_held", imem_addr, 16'h3000);
    check("disc_pc", pc, 16'h4000);
    step(1, 1, 0, 0, 16'h0, 100);
    check("disc_dropped", fq_count, 3'd0);
    step(1, 0, 0, 0, 16'h0, 100);
    check("disc_new_addr", imem_addr, 16'h4000);
    step(0, 0, 0, 0, 16'h0, 100);
    check("disc_first_npc", instr_npc, 16'h4001);

    // Redirect coincident with ack; then an unqualified br_taken.
    apply_reset();
    step(1, 1, 0, 0, 16'h0, 0);
    step(1, 1, 1, 1, 16'h5000, 100);
    check("ackredir_empty", fq_count, 3'd0);
    check("ackredir_valid", instr_valid, 1'b0);
    step(1, 1, 0, 0, 16'h0, 0);
    check("ackredir_addr", imem_addr, 16'h5000);
    step(0, 1, 0, 0, 16'h0, 100);
    step(0, 1, 0, 0, 16'h0, 100);
    step(0, 1, 1, 0, 16'h1234, 100);
    check("br_no_upc_pc", pc, 16'h5001);

    // PC wrap at the top of memory.
    step(0, 1, 1, 1, 16'hFFFF, 0);
    step(1, 0, 0, 0, 16'h0, 100);
    step(0, 0, 0, 0, 16'h0, 100);
    check("wrap_npc", instr_npc, 16'h0000);
    check("wrap_pc", pc, 16'h0000);
    step(0, 1, 0, 0, 16'h0, 100);

    // Reset asserted in the middle of a request with a queued entry.
    apply_reset();
    step(1, 0, 0, 0, 16'h0, 100);
    step(1, 0, 0, 0, 16'h0, 100);
    step(1, 0, 0, 0, 16'h0, 0);
    #2 reset = 1'b0;
    #1;
    check("midrst_req", imem_req, 1'b0);
    check("midrst_pc", pc, 16'h3000);
    check("midrst_count", fq_count, 3'd0);
    model_reset();
    @(posedge clock);
    #3 reset = 1'b1;
    enable_fetch = 1'b0;
    imem_ack     = 1'b1;
    imem_rdata   = 16'hBEEF;
    do_cycle();
    check("late_ack_count", fq_count, 3'd0);
    check("late_ack_req", imem_req, 1'b0);

    // Randomized traffic against the model.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [15:0] ta;
      ta = ($urandom_range(0, 3) == 0) ? 16'hFFFE + 16'($urandom_range(0, 2))
                                       : 16'($urandom);
      step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, ta, 50);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
